// File: rtl/pipeline_par_check_pkg.sv
// Shared widths and parity sense for the receive-side check pipeline.
// Build option: define PIPE_PAR_ODD_EN to expect odd parity instead of even.
package pipeline_defs;

    localparam int OPC_W      = 3;
    localparam int FNC_W      = 8;
    localparam int DATA_W_DEF = 4;

`ifdef PIPE_PAR_ODD_EN
    localparam logic PAR_ODD = 1'b1;
`else
    localparam logic PAR_ODD = 1'b0;
`endif

    // red is the XOR of result and parity bit; a mismatch with the expected sense is an error
    function automatic logic par_mismatch(input logic red);
        return red != PAR_ODD;
    endfunction

endpackage

// File: rtl/pipeline_par_check_dec.sv
// 3-to-8 one-hot decoder, inverse of the opcode encoder upstream.
module pipeline_dec
    import pipeline_defs::*;
(
    input  logic [OPC_W-1:0] opcode_i,
    output logic [FNC_W-1:0] fncode_o
);

    always_comb begin
        fncode_o = FNC_W'(1) << opcode_i;
    end

endmodule

// File: rtl/pipeline_par_check.sv
// Two-stage valid/ready pipeline: decode opcode to one-hot, check parity, count errors.
// Parity sense follows PIPE_PAR_ODD_EN (odd when defined, even otherwise).
module pipeline_par_check
    import pipeline_defs::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int ERR_W  = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [OPC_W-1:0]  in_opcode,
    input  logic [DATA_W-1:0] in_result,
    input  logic              in_parity,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [FNC_W-1:0]  out_fncode,
    output logic [DATA_W-1:0] out_result,
    output logic              out_par_err,
    input  logic              err_clr,
    output logic [ERR_W-1:0]  err_count,
    output logic              err_sticky
);

    logic              s1_valid_q;
    logic [OPC_W-1:0]  s1_opcode_q;
    logic [DATA_W-1:0] s1_result_q;
    logic              s1_parity_q;

    logic              out_valid_q;
    logic [FNC_W-1:0]  out_fncode_q;
    logic [DATA_W-1:0] out_result_q;
    logic              out_par_err_q;

    logic [ERR_W-1:0]  err_count_q, err_count_d;
    logic              err_sticky_q, err_sticky_d;

    logic              en1, en2, out_xfer, s1_par_err;
    logic [FNC_W-1:0]  s1_fncode;

    // A stage advances when it is empty or its successor is advancing
    assign en2      = !out_valid_q || out_ready;
    assign en1      = !s1_valid_q || en2;
    assign in_ready = en1 && !rst;
    assign out_xfer = out_valid_q && out_ready;

    pipeline_dec u_dec (
        .opcode_i (s1_opcode_q),
        .fncode_o (s1_fncode)
    );

    assign s1_par_err = par_mismatch(^{s1_result_q, s1_parity_q});

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid_q  <= 1'b0;
            s1_opcode_q <= '0;
            s1_result_q <= '0;
            s1_parity_q <= 1'b0;
        end else if (en1) begin
            s1_valid_q <= in_valid;
            if (in_valid) begin
                s1_opcode_q <= in_opcode;
                s1_result_q <= in_result;
                s1_parity_q <= in_parity;
            end
        end
    end

    // Output payload only reloads with a real word, so it holds across bubbles
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid_q   <= 1'b0;
            out_fncode_q  <= '0;
            out_result_q  <= '0;
            out_par_err_q <= 1'b0;
        end else if (en2) begin
            out_valid_q <= s1_valid_q;
            if (s1_valid_q) begin
                out_fncode_q  <= s1_fncode;
                out_result_q  <= s1_result_q;
                out_par_err_q <= s1_par_err;
            end
        end
    end

    // Counting on the output transfer counts a stalled word exactly once; clear wins
    always_comb begin
        err_count_d  = err_count_q;
        err_sticky_d = err_sticky_q;
        if (err_clr) begin
            err_count_d  = '0;
            err_sticky_d = 1'b0;
        end else if (out_xfer && out_par_err_q) begin
            err_sticky_d = 1'b1;
            if (err_count_q != '1) begin
                err_count_d = err_count_q + ERR_W'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_count_q  <= '0;
            err_sticky_q <= 1'b0;
        end else begin
            err_count_q  <= err_count_d;
            err_sticky_q <= err_sticky_d;
        end
    end

    assign out_valid   = out_valid_q;
    assign out_fncode  = out_fncode_q;
    assign out_result  = out_result_q;
    assign out_par_err = out_par_err_q;
    assign err_count   = err_count_q;
    assign err_sticky  = err_sticky_q;

endmodule

// File: tb/tb_pipeline_par_check.sv
// Scoreboard bench for pipeline_par_check (DATA_W=4, ERR_W=2); honours PIPE_PAR_ODD_EN.
module tb_pipeline_par_check;

    localparam int DW = 4;
    localparam int EW = 2;
`ifdef PIPE_PAR_ODD_EN
    localparam logic ODD = 1'b1;
`else
    localparam logic ODD = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          in_valid = 1'b0, in_ready;
    logic [2:0]    in_opcode = '0;
    logic [DW-1:0] in_result = '0;
    logic          in_parity = 1'b0;
    logic          out_valid, out_ready = 1'b0;
    logic [7:0]    out_fncode;
    logic [DW-1:0] out_result;
    logic          out_par_err;
    logic          err_clr = 1'b0;
    logic [EW-1:0] err_count;
    logic          err_sticky;

    always #5 clk = ~clk;

    pipeline_par_check #(.DATA_W(DW), .ERR_W(EW)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_opcode(in_opcode), .in_result(in_result), .in_parity(in_parity),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_fncode(out_fncode), .out_result(out_result), .out_par_err(out_par_err),
        .err_clr(err_clr), .err_count(err_count), .err_sticky(err_sticky)
    );

    int            total = 0;
    int            bad = 0;
    logic [12:0]   sb[$];
    logic [EW-1:0] exp_cnt = '0;
    logic          exp_stk = 1'b0;
    logic          acc, ox, ov;
    logic [12:0]   w, e;
    // parity bit that makes 4'b0111 an error word in either build
    logic          perr;

    function automatic logic [12:0] expw(input logic [2:0] op, input logic [DW-1:0] r, input logic p);
        logic [7:0] f;
        f = 8'h00;
        f[op] = 1'b1;
        return {f, r, ((^{r, p}) != ODD)};
    endfunction

    // One clock: drive at negedge, sample just after, update the error model after posedge
    task automatic cyc(input logic v, input logic [2:0] op, input logic [DW-1:0] r, input logic p,
                       input logic ordy, input logic clr,
                       output logic a, output logic x, output logic vo, output logic [12:0] word);
        logic xerr;
        @(negedge clk);
        in_valid = v; in_opcode = op; in_result = r; in_parity = p;
        out_ready = ordy; err_clr = clr;
        #1;
        a    = in_valid && in_ready;
        x    = out_valid && out_ready;
        vo   = out_valid;
        word = {out_fncode, out_result, out_par_err};
        xerr = (sb.size() > 0) ? sb[0][0] : 1'b0;
        if (a) sb.push_back(expw(op, r, p));
        @(posedge clk);
        #1;
        if (clr) begin
            exp_cnt = '0;
            exp_stk = 1'b0;
        end else if (x && xerr) begin
            exp_stk = 1'b1;
            if (exp_cnt != '1) exp_cnt = exp_cnt + 1'b1;
        end
    endtask

    task automatic test_reset();
        #1 rst = 1'b1;
        #2;
        total++; if ({out_valid, in_ready, err_sticky} !== 3'b000) begin bad++;
            $display("FAIL reset_flags got v/rdy/stk=%b want 000", {out_valid, in_ready, err_sticky}); end
        total++; if ({out_fncode, out_result, out_par_err} !== 13'h0) begin bad++;
            $display("FAIL reset_data got %h want 0", {out_fncode, out_result, out_par_err}); end
        total++; if (err_count !== '0) begin bad++;
            $display("FAIL reset_count got %0d want 0", err_count); end
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        total++; if (in_ready !== 1'b1) begin bad++;
            $display("FAIL reset_release_ready got %b want 1", in_ready); end
    endtask

    task automatic test_single();
        int lat = -1;
        cyc(1'b1, 3'd3, 4'b1010, 1'b0, 1'b1, 1'b0, acc, ox, ov, w);
        total++; if (acc !== 1'b1) begin bad++; $display("FAIL single_accept got %b want 1", acc); end
        for (int c = 1; c <= 6 && lat < 0; c++) begin
            cyc(1'b0, 3'd0, 4'd0, 1'b0, 1'b1, 1'b0, acc, ox, ov, w);
            if (ox) begin
                lat = c;
                e = (sb.size() > 0) ? sb.pop_front() : 'x;
                total++; if (w !== e) begin bad++; $display("FAIL single_word got %h want %h", w, e); end
            end
        end
        total++; if (lat != 2) begin bad++; $display("FAIL single_latency got %0d want 2", lat); end
        total++; if ({err_sticky, err_count} !== {exp_stk, exp_cnt}) begin bad++;
            $display("FAIL single_err got %b/%0d want %b/%0d", err_sticky, err_count, exp_stk, exp_cnt); end
    endtask

    task automatic test_parity_err();
        int nout = 0;
        cyc(1'b1, 3'd7, 4'b0111, 1'b0, 1'b1, 1'b0, acc, ox, ov, w);
        for (int c = 0; c < 4; c++) begin
            cyc(1'b0, 3'd0, 4'd0, 1'b0, 1'b1, 1'b0, acc, ox, ov, w);
            if (ox) begin
                nout++;
                e = (sb.size() > 0) ? sb.pop_front() : 'x;
                total++; if (w !== e) begin bad++; $display("FAIL perr_word got %h want %h", w, e); end
            end
        end
        total++; if (nout != 1) begin bad++; $display("FAIL perr_nout got %0d want 1", nout); end
        total++; if ({err_sticky, err_count} !== {exp_stk, exp_cnt}) begin bad++;
            $display("FAIL perr_err got %b/%0d want %b/%0d", err_sticky, err_count, exp_stk, exp_cnt); end
    endtask

    task automatic test_parity_sense();
        int nout = 0;
        cyc(1'b1, 3'd1, 4'b1010, 1'b1, 1'b1, 1'b0, acc, ox, ov, w);
        cyc(1'b1, 3'd2, 4'b1010, 1'b0, 1'b1, 1'b0, acc, ox, ov, w);
        total++; if (acc !== 1'b1) begin bad++; $display("FAIL sense_b2b_accept got %b want 1", acc); end
        for (int c = 0; c < 4; c++) begin
            cyc(1'b0, 3'd0, 4'd0, 1'b0, 1'b1, 1'b0, acc, ox, ov, w);
            if (ox) begin
                nout++;
                e = (sb.size() > 0) ? sb.pop_front() : 'x;
                total++; if (w !== e) begin bad++; $display("FAIL sense_word got %h want %h", w, e); end
            end
        end
        total++; if (nout != 2) begin bad++; $display("FAIL sense_nout got %0d want 2", nout); end
    endtask

    task automatic test_backpressure();
        int idx = 0, nout = 0;
        logic [12:0] hold = '0;
        logic [DW-1:0] r;
        logic p;
        for (int c = 0; c < 80; c++) begin
            r = 4'(idx * 5 + 1);
            p = (^r) ^ ODD;
            if (idx == 0) p = ~p;
            cyc(idx < 8, 3'(idx), r, p, c >= 5, 1'b0, acc, ox, ov, w);
            if (acc) idx++;
            if (c == 2) begin
                hold = w;
                total++; if ({acc, ov} !== 2'b01) begin bad++;
                    $display("FAIL bp_stall_start got acc/ov=%b%b want 01", acc, ov); end
            end
            if (c == 3 || c == 4) begin
                total++; if ({acc, ov} !== 2'b01 || w !== hold) begin bad++;
                    $display("FAIL bp_stall_hold got acc/ov=%b%b word=%h want 01 %h", acc, ov, w, hold); end
            end
            if (c == 4) begin
                total++; if (idx != 2) begin bad++; $display("FAIL bp_accepted got %0d want 2", idx); end
            end
            if (ox) begin
                nout++;
                e = (sb.size() > 0) ? sb.pop_front() : 'x;
                total++; if (w !== e) begin bad++; $display("FAIL bp_word got %h want %h", w, e); end
            end
            if (idx == 8 && sb.size() == 0 && c > 5) break;
        end
        total++; if (nout != 8 || idx != 8) begin bad++;
            $display("FAIL bp_count got in=%0d out=%0d want 8/8", idx, nout); end
        total++; if ({err_sticky, err_count} !== {exp_stk, exp_cnt}) begin bad++;
            $display("FAIL bp_err got %b/%0d want %b/%0d", err_sticky, err_count, exp_stk, exp_cnt); end
    endtask

    task automatic test_sat_clear();
        cyc(1'b0, 3'd0, 4'd0, 1'b0, 1'b1, 1'b1, acc, ox, ov, w);
        total++; if ({err_sticky, err_count} !== 3'b000) begin bad++;
            $display("FAIL clr_idle got %b/%0d want 0/0", err_sticky, err_count); end
        for (int c = 0; c < 12; c++) begin
            cyc(c < 5, 3'(c), 4'b0111, perr, 1'b1, 1'b0, acc, ox, ov, w);
            if (c < 5) begin
                total++; if (acc !== 1'b1) begin bad++; $display("FAIL sat_accept%0d got %b want 1", c, acc); end
            end
            if (ox) begin
                e = (sb.size() > 0) ? sb.pop_front() : 'x;
                total++; if (w !== e) begin bad++; $display("FAIL sat_word got %h want %h", w, e); end
            end
        end
        total++; if (err_count !== 2'd3 || err_sticky !== 1'b1 || exp_cnt !== 2'd3) begin bad++;
            $display("FAIL sat_count got %b/%0d want 1/3", err_sticky, err_count); end
        cyc(1'b1, 3'd6, 4'b0111, perr, 1'b1, 1'b0, acc, ox, ov, w);
        cyc(1'b0, 3'd0, 4'd0, 1'b0, 1'b1, 1'b0, acc, ox, ov, w);
        cyc(1'b0, 3'd0, 4'd0, 1'b0, 1'b1, 1'b1, acc, ox, ov, w);
        e = (sb.size() > 0) ? sb.pop_front() : 'x;
        total++; if (ox !== 1'b1 || w !== e) begin bad++;
            $display("FAIL clr_xfer got ox=%b word=%h want 1 %h", ox, w, e); end
        total++; if ({err_sticky, err_count} !== 3'b000) begin bad++;
            $display("FAIL clr_wins got %b/%0d want 0/0", err_sticky, err_count); end
    endtask

    task automatic test_async_reset();
        int lat = -1;
        cyc(1'b1, 3'd5, 4'b0111, perr, 1'b1, 1'b0, acc, ox, ov, w);
        for (int c = 0; c < 3; c++) begin
            cyc(1'b0, 3'd0, 4'd0, 1'b0, 1'b1, 1'b0, acc, ox, ov, w);
            if (ox) begin
                e = (sb.size() > 0) ? sb.pop_front() : 'x;
                total++; if (w !== e) begin bad++; $display("FAIL ar_pre_word got %h want %h", w, e); end
            end
        end
        total++; if (err_count !== 2'd1) begin bad++; $display("FAIL ar_pre_count got %0d want 1", err_count); end
        cyc(1'b1, 3'd1, 4'd3, 1'b0, 1'b0, 1'b0, acc, ox, ov, w);
        cyc(1'b1, 3'd2, 4'd5, 1'b0, 1'b0, 1'b0, acc, ox, ov, w);
        #2;
        in_valid = 1'b0;
        rst = 1'b1;
        #1;
        total++; if ({out_valid, in_ready, err_sticky} !== 3'b000 || err_count !== '0) begin bad++;
            $display("FAIL ar_immediate got v/rdy/stk=%b cnt=%0d want 000 0",
                     {out_valid, in_ready, err_sticky}, err_count); end
        sb.delete();
        exp_cnt = '0;
        exp_stk = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        cyc(1'b1, 3'd4, 4'b1100, 1'b0, 1'b1, 1'b0, acc, ox, ov, w);
        total++; if ({acc, ox} !== 2'b10) begin bad++; $display("FAIL ar_first got acc/ox=%b%b want 10", acc, ox); end
        for (int c = 1; c <= 6 && lat < 0; c++) begin
            cyc(1'b0, 3'd0, 4'd0, 1'b0, 1'b1, 1'b0, acc, ox, ov, w);
            if (ox) begin
                lat = c;
                e = (sb.size() > 0) ? sb.pop_front() : 'x;
                total++; if (w !== e) begin bad++; $display("FAIL ar_word got %h want %h", w, e); end
            end
        end
        total++; if (lat != 2) begin bad++; $display("FAIL ar_latency got %0d want 2", lat); end
    endtask

    initial begin
        perr = ~ODD ^ (^4'b0111);
        test_reset();
        test_single();
        test_parity_err();
        test_parity_sense();
        test_backpressure();
        test_sat_clear();
        test_async_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
